// File: rtl/btn_switch_capture_pkg.sv
//------------------------------------------------------------------------------
// Module : btn_switch_capture_pkg
// Brief  : Shared debounce state encoding and switch field positions.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package btn_switch_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int c_A_HI   = 11;
  localparam int c_A_LO   = 8;
  localparam int c_B_HI   = 7;
  localparam int c_B_LO   = 4;
  localparam int c_SEL_HI = 3;
  localparam int c_SEL_LO = 0;

  localparam int c_BTN_LOAD_AB  = 0;
  localparam int c_BTN_LOAD_SEL = 1;

endpackage

`default_nettype wire

// File: rtl/btn_switch_capture_if.sv
//------------------------------------------------------------------------------
// Module : btn_switch_capture_if
// Brief  : Board-pin inputs and captured operand outputs of the capture block.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface btn_switch_capture_if;
  logic [1:0]  btn;
  logic [15:0] switches;
  logic [3:0]  a_out;
  logic [3:0]  b_out;
  logic [3:0]  sel_out;
  logic        ab_load;
  logic        sel_load;
  logic [1:0]  btn_level;
  logic        operands_valid;

  modport master (
    output btn, switches,
    input  a_out, b_out, sel_out, ab_load, sel_load, btn_level, operands_valid
  );

  modport slave (
    input  btn, switches,
    output a_out, b_out, sel_out, ab_load, sel_load, btn_level, operands_valid
  );
endinterface

`default_nettype wire

// File: rtl/btn_switch_capture_debounce_fsm.sv
//------------------------------------------------------------------------------
// Module : debounce_fsm
// Brief  : Debounces one synchronized button into a level and a press strobe.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debounce_fsm
  import btn_switch_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic level,
  output logic press_pulse,
  output logic press_accept
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == c_CNT_LAST);
  // Combinational twin of the strobe so captures land on the same edge.
  assign press_accept = (r_state == ST_PRESS_WAIT) && sync_in && w_cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sync_in) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_in) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_done) begin
            r_state <= ST_HELD;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!sync_in) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_in) begin
            r_state <= ST_HELD;
          end else if (w_cnt_done) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign level       = r_level;
  assign press_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/btn_switch_capture.sv
//------------------------------------------------------------------------------
// Module : btn_switch_capture
// Brief  : Syncs/debounces buttons and switches, captures ALU operands on press.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_switch_capture
  import btn_switch_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_switch_capture_if.slave  bus
);

  logic [1:0]  r_btn_s1;
  logic [1:0]  r_btn_s2;
  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [3:0]  r_sel;
  logic        r_valid;
  logic [1:0]  w_level;
  logic [1:0]  w_pulse;
  logic [1:0]  w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= bus.btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= bus.switches;
      r_sw_s2  <= r_sw_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
      debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce_fsm (
        .clk          (clk),
        .rst          (rst),
        .sync_in      (r_btn_s2[gi]),
        .level        (w_level[gi]),
        .press_pulse  (w_pulse[gi]),
        .press_accept (w_accept[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept[c_BTN_LOAD_AB]) begin
        r_a     <= r_sw_s2[c_A_HI:c_A_LO];
        r_b     <= r_sw_s2[c_B_HI:c_B_LO];
        r_valid <= 1'b1;
      end
      if (w_accept[c_BTN_LOAD_SEL]) begin
        r_sel <= r_sw_s2[c_SEL_HI:c_SEL_LO];
      end
    end
  end

  assign bus.a_out          = r_a;
  assign bus.b_out          = r_b;
  assign bus.sel_out        = r_sel;
  assign bus.ab_load        = w_pulse[c_BTN_LOAD_AB];
  assign bus.sel_load       = w_pulse[c_BTN_LOAD_SEL];
  assign bus.btn_level      = w_level;
  assign bus.operands_valid = r_valid;

endmodule

`default_nettype wire
